// File: rtl/chrono_counter.sv
// Stopwatch/timer: a millisecond prescaler drives an H:MM:SS.mmm counter that counts up or down,
// with start/stop, lap capture, preset load and clear.
module chrono_counter #(
    parameter int CLK_PER_MS = 50000,
    parameter int HOURS_W    = 4,
    parameter int MAX_HOURS  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               st_signal,
    input  logic               lap,
    input  logic               clear,
    input  logic               mode,
    input  logic               load,
    input  logic [HOURS_W-1:0] pre_h,
    input  logic [5:0]         pre_m,
    input  logic [5:0]         pre_s,
    input  logic [9:0]         pre_ms,
    output logic [HOURS_W-1:0] hours,
    output logic [5:0]         minutes,
    output logic [5:0]         seconds,
    output logic [9:0]         milliseconds,
    output logic [HOURS_W-1:0] lap_h,
    output logic [5:0]         lap_m,
    output logic [5:0]         lap_s,
    output logic [9:0]         lap_ms,
    output logic               lap_valid,
    output logic               running,
    output logic               overflow,
    output logic               expired
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0]      PRESC_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [HOURS_W-1:0] H_MAX     = HOURS_W'(MAX_HOURS);

    function automatic logic [9:0] sat_ms(input logic [9:0] v);
        return (v > 10'd999) ? 10'd999 : v;
    endfunction

    function automatic logic [5:0] sat_60(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [HOURS_W-1:0] sat_h(input logic [HOURS_W-1:0] v);
        return (v > H_MAX) ? H_MAX : v;
    endfunction

    logic [HOURS_W-1:0] r_h, r_lap_h;
    logic [5:0]         r_m, r_s, r_lap_m, r_lap_s;
    logic [9:0]         r_ms, r_lap_ms;
    logic [PW-1:0]      r_presc;
    logic               r_running, r_mode, r_lap_valid, r_ovf, r_exp;
    logic               r_st_d, r_lap_d;

    logic w_st_edge, w_lap_edge, w_tick;
    logic w_ms_max, w_s_max, w_m_max, w_h_max;
    logic w_ms_z, w_s_z, w_m_z, w_h_z;
    logic w_up_wrap, w_dn_expire;
    logic [HOURS_W-1:0] w_up_h, w_dn_h;
    logic [5:0]         w_up_m, w_up_s, w_dn_m, w_dn_s;
    logic [9:0]         w_up_ms, w_dn_ms;

    assign w_st_edge  = st_signal & ~r_st_d;
    assign w_lap_edge = lap & ~r_lap_d;
    assign w_tick     = r_running && (r_presc == PRESC_MAX);

    assign w_ms_max = (r_ms == 10'd999);
    assign w_s_max  = (r_s == 6'd59);
    assign w_m_max  = (r_m == 6'd59);
    assign w_h_max  = (r_h == H_MAX);
    assign w_ms_z   = (r_ms == 10'd0);
    assign w_s_z    = (r_s == 6'd0);
    assign w_m_z    = (r_m == 6'd0);
    assign w_h_z    = (r_h == '0);

    // Carry chain for counting up; the hour field wraps only when every lower field is at its limit.
    assign w_up_ms   = w_ms_max ? 10'd0 : r_ms + 10'd1;
    assign w_up_s    = w_ms_max ? (w_s_max ? 6'd0 : r_s + 6'd1) : r_s;
    assign w_up_m    = (w_ms_max && w_s_max) ? (w_m_max ? 6'd0 : r_m + 6'd1) : r_m;
    assign w_up_h    = (w_ms_max && w_s_max && w_m_max) ? (w_h_max ? '0 : r_h + HOURS_W'(1)) : r_h;
    assign w_up_wrap = w_ms_max && w_s_max && w_m_max && w_h_max;

    // Borrow chain for counting down; a tick at or onto all-zero is the expiry case.
    assign w_dn_ms     = w_ms_z ? 10'd999 : r_ms - 10'd1;
    assign w_dn_s      = w_ms_z ? (w_s_z ? 6'd59 : r_s - 6'd1) : r_s;
    assign w_dn_m      = (w_ms_z && w_s_z) ? (w_m_z ? 6'd59 : r_m - 6'd1) : r_m;
    assign w_dn_h      = (w_ms_z && w_s_z && w_m_z) ? r_h - HOURS_W'(1) : r_h;
    assign w_dn_expire = w_h_z && w_m_z && w_s_z && (r_ms <= 10'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h         <= '0;
            r_m         <= '0;
            r_s         <= '0;
            r_ms        <= '0;
            r_lap_h     <= '0;
            r_lap_m     <= '0;
            r_lap_s     <= '0;
            r_lap_ms    <= '0;
            r_presc     <= '0;
            r_running   <= 1'b0;
            r_mode      <= 1'b0;
            r_lap_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_exp       <= 1'b0;
            r_st_d      <= 1'b0;
            r_lap_d     <= 1'b0;
        end else begin
            r_st_d  <= st_signal;
            r_lap_d <= lap;
            r_ovf   <= 1'b0;
            r_exp   <= 1'b0;
            if (w_st_edge) begin
                r_running <= ~r_running;
                if (!r_running) r_mode <= mode;
            end
            if (clear) begin
                r_h         <= '0;
                r_m         <= '0;
                r_s         <= '0;
                r_ms        <= '0;
                r_lap_h     <= '0;
                r_lap_m     <= '0;
                r_lap_s     <= '0;
                r_lap_ms    <= '0;
                r_presc     <= '0;
                r_lap_valid <= 1'b0;
            end else if (!r_running) begin
                if (load) begin
                    r_h  <= sat_h(pre_h);
                    r_m  <= sat_60(pre_m);
                    r_s  <= sat_60(pre_s);
                    r_ms <= sat_ms(pre_ms);
                end
            end else begin
                if (w_lap_edge) begin
                    r_lap_h     <= r_h;
                    r_lap_m     <= r_m;
                    r_lap_s     <= r_s;
                    r_lap_ms    <= r_ms;
                    r_lap_valid <= 1'b1;
                end
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    if (!r_mode) begin
                        r_h   <= w_up_h;
                        r_m   <= w_up_m;
                        r_s   <= w_up_s;
                        r_ms  <= w_up_ms;
                        r_ovf <= w_up_wrap;
                    end else if (w_dn_expire) begin
                        // Expiry overrides a coincident start/stop toggle: the timer always ends stopped.
                        r_h       <= '0;
                        r_m       <= '0;
                        r_s       <= '0;
                        r_ms      <= '0;
                        r_exp     <= 1'b1;
                        r_running <= 1'b0;
                    end else begin
                        r_h  <= w_dn_h;
                        r_m  <= w_dn_m;
                        r_s  <= w_dn_s;
                        r_ms <= w_dn_ms;
                    end
                end
            end
        end
    end

    assign hours        = r_h;
    assign minutes      = r_m;
    assign seconds      = r_s;
    assign milliseconds = r_ms;
    assign lap_h        = r_lap_h;
    assign lap_m        = r_lap_m;
    assign lap_s        = r_lap_s;
    assign lap_ms       = r_lap_ms;
    assign lap_valid    = r_lap_valid;
    assign running      = r_running;
    assign overflow     = r_ovf;
    assign expired      = r_exp;

endmodule

// File: doc/chrono_counter.md
CHRONO_COUNTER -- requirements
Module: chrono_counter

Interface
REQ-001 Parameter CLK_PER_MS, default 50000, clk cycles per millisecond tick (>=1).
REQ-002 Parameter HOURS_W, default 4, width of hour fields.
REQ-003 Parameter MAX_HOURS, default 9, highest hour value (<=2^HOURS_W-1).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 st_signal  input  1  start/stop request; a rising edge toggles running.
REQ-007 lap  input  1  lap request; a rising edge captures the time into the lap fields.
REQ-008 clear  input  1  level; zeroes time, prescaler and lap fields.
REQ-009 mode  input  1  0 = count up (stopwatch), 1 = count down (timer).
REQ-010 load  input  1  level; loads preset fields into time while stopped.
REQ-011 pre_h/pre_m/pre_s/pre_ms  input  HOURS_W/6/6/10  preset time.
REQ-012 hours/minutes/seconds/milliseconds  output  HOURS_W/6/6/10  current time, registered.
REQ-013 lap_h/lap_m/lap_s/lap_ms  output  HOURS_W/6/6/10  captured lap time, registered.
REQ-014 lap_valid  output  1  high while the lap fields hold a capture.
REQ-015 running  output  1  high while counting.
REQ-016 overflow  output  1  one-cycle pulse on up-count wrap.
REQ-017 expired  output  1  one-cycle pulse when a down count reaches zero.

Function
REQ-018 st_signal and lap SHALL be edge-detected against their previous-cycle sample; a rising edge acts at the same clk edge that samples input=1 with previous sample=0.
REQ-019 Prescaler SHALL advance only while running, emitting a tick when it equals CLK_PER_MS-1 and wrapping to 0; it SHALL hold its value while stopped.
REQ-020 Mode SHALL be latched when running goes 0->1; mode changes while running SHALL be ignored.
REQ-021 Up count on tick: ms 0..999, then s 0..59, m 0..59, h 0..MAX_HOURS, each carrying into the next field.
REQ-022 Up tick at MAX_HOURS:59:59.999 SHALL wrap all fields to 0 and pulse overflow; running stays high.
REQ-023 Down count on tick SHALL decrement with borrow (ms 0->999, s 0->59, m 0->59).
REQ-024 The down tick that reaches all-zero SHALL pulse expired and clear running at the same edge.
REQ-025 Starting in down mode at all-zero SHALL set running; the first tick then pulses expired, clears running and leaves time at 0.
REQ-026 load SHALL act only when running=0; preset fields above their limit (999/59/59/MAX_HOURS) SHALL saturate to that limit.
REQ-027 Lap edge while running SHALL capture the pre-tick time of that cycle and set lap_valid; a lap edge while stopped SHALL be ignored.
REQ-028 clear SHALL zero time, prescaler, lap fields and lap_valid without changing running.
REQ-029 Priority: reset > clear > load > tick.
REQ-030 A start/stop edge coincident with a tick SHALL apply the tick according to the running value before the toggle.
REQ-031 Outputs SHALL never leave their legal ranges.

Reset
REQ-032 reset=1 at a clk edge SHALL zero all time and lap fields and the prescaler, clear running, lap_valid, overflow and expired, and clear the edge-detector history to 0.
REQ-033 Reset mid-count SHALL take effect at that edge regardless of other inputs.
REQ-034 After reset, mode latches 0 and the block is stopped.

Verification (CLK_PER_MS=2, MAX_HOURS=9 unless noted)
REQ-035 Reset, st_signal pulse, run 2000 clk -> time 0:00:01.000, running=1; second pulse -> time freezes.
REQ-036 Load 9:59:59.998, mode=0, start, 4 clk -> time 0:00:00.000, one overflow pulse.
REQ-037 Load 0:00:00.002, mode=1, start -> after 4 clk time=0, expired pulses once, running=0.
REQ-038 Running at 0:00:00.500, lap edge coincident with tick -> lap fields 0:00:00.500, lap_valid=1, time 0:00:00.501.
REQ-039 load while running with pre 5:00:00.000 -> ignored; load while stopped with pre_m=63 -> minutes=59.
REQ-040 clear and reset each asserted mid-count -> all fields 0; after clear running stays 1, after reset running=0.
